// File: rtl/rr_flush_arbiter.sv
// Two-source round-robin arbiter feeding shared_resource through one registered slot.
// Flushed requests are never granted or stalled, and a flushed held request is dropped.
module rr_flush_arbiter #(
  parameter int ADDR_W = 8,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in_address_1,
  input  logic [ID_W-1:0]   in_id_1,
  input  logic              in_valid_1,
  input  logic              in_flush_1,
  input  logic [ID_W-1:0]   in_flush_id_1,
  input  logic [ADDR_W-1:0] in_address_2,
  input  logic [ID_W-1:0]   in_id_2,
  input  logic              in_valid_2,
  input  logic              in_flush_2,
  input  logic [ID_W-1:0]   in_flush_id_2,
  input  logic              in_ready,
  output logic              out_stall_1,
  output logic              out_stall_2,
  output logic [ADDR_W-1:0] out_address,
  output logic [ID_W-1:0]   out_id,
  output logic              out_choice,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_grants_1,
  output logic [CNT_W-1:0]  out_grants_2,
  output logic [CNT_W-1:0]  out_drops
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic              out_valid_q,   out_valid_d;
  logic [ADDR_W-1:0] out_address_q, out_address_d;
  logic [ID_W-1:0]   out_id_q,      out_id_d;
  logic              out_choice_q,  out_choice_d;
  logic              last_q,        last_d;
  logic [CNT_W-1:0]  grants_1_q,    grants_1_d;
  logic [CNT_W-1:0]  grants_2_q,    grants_2_d;
  logic [CNT_W-1:0]  drops_q,       drops_d;

  logic fl_1, fl_2, elig_1, elig_2;
  logic held_flush, xfer, drop, load;
  logic gnt_1, gnt_2;

  // last_q uses the out_choice encoding: 1 means source 2 won last, so source 1 wins the next tie
  always_comb begin
    fl_1   = in_valid_1 && in_flush_1 && (in_flush_id_1 == in_id_1);
    fl_2   = in_valid_2 && in_flush_2 && (in_flush_id_2 == in_id_2);
    elig_1 = in_valid_1 && !fl_1;
    elig_2 = in_valid_2 && !fl_2;
    held_flush = out_choice_q ? (in_flush_2 && (in_flush_id_2 == out_id_q))
                              : (in_flush_1 && (in_flush_id_1 == out_id_q));
    xfer  = out_valid_q && in_ready;
    drop  = out_valid_q && !in_ready && held_flush;
    load  = !out_valid_q || xfer || drop;
    // No grant can be issued while reset is asserted, so a valid head reads as stalled.
    gnt_1 = reset && load && elig_1 && (!elig_2 || last_q);
    gnt_2 = reset && load && elig_2 && (!elig_1 || !last_q);
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_address_d = out_address_q;
    out_id_d      = out_id_q;
    out_choice_d  = out_choice_q;
    last_d        = last_q;
    grants_1_d    = grants_1_q;
    grants_2_d    = grants_2_q;
    drops_d       = drops_q;
    if (gnt_1 || gnt_2) begin
      out_valid_d   = 1'b1;
      out_address_d = gnt_2 ? in_address_2 : in_address_1;
      out_id_d      = gnt_2 ? in_id_2 : in_id_1;
      out_choice_d  = gnt_2;
      last_d        = gnt_2;
    end else if (xfer || drop) begin
      out_valid_d = 1'b0;
    end
    if (gnt_1) grants_1_d = sat_inc(grants_1_q);
    if (gnt_2) grants_2_d = sat_inc(grants_2_q);
    if (drop)  drops_d    = sat_inc(drops_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_address_q <= '0;
      out_id_q      <= '0;
      out_choice_q  <= 1'b0;
      last_q        <= 1'b1;
      grants_1_q    <= '0;
      grants_2_q    <= '0;
      drops_q       <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_address_q <= out_address_d;
      out_id_q      <= out_id_d;
      out_choice_q  <= out_choice_d;
      last_q        <= last_d;
      grants_1_q    <= grants_1_d;
      grants_2_q    <= grants_2_d;
      drops_q       <= drops_d;
    end
  end

  assign out_stall_1  = elig_1 && !gnt_1;
  assign out_stall_2  = elig_2 && !gnt_2;
  assign out_valid    = out_valid_q;
  assign out_address  = out_address_q;
  assign out_id       = out_id_q;
  assign out_choice   = out_choice_q;
  assign out_grants_1 = grants_1_q;
  assign out_grants_2 = grants_2_q;
  assign out_drops    = drops_q;

endmodule
